// File: rtl/slowclk_gen.sv
// rtl/slowclk_gen.sv - debounced run/pause/single-step slow clock generator
module slowclk_gen #(
   parameter int HALF_PERIOD     = 6000000,
   parameter int DEBOUNCE_CYCLES = 120000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_pause,
   input  logic btn_step,
   output logic slowclk,
   output logic tick,
   output logic running
);

   // Divider and debounce counter widths; a 1-bit floor keeps the minimum parameter values legal.
   localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(HALF_PERIOD - 1);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

   // Button index 0 is pause, index 1 is step.
   localparam int BP = 0;
   localparam int BS = 1;

   typedef enum logic [2:0] {
      ST_RUN,
      ST_STOPPING,
      ST_PAUSED,
      ST_STEP_HI,
      ST_STEP_LO
   } state_t;

   logic [1:0]         btn_raw;
   logic [1:0]         sync1_q;
   logic [1:0]         sync2_q;
   logic [1:0]         deb_q;
   logic [1:0]         deb_d;
   logic [1:0]         press_q;
   logic [1:0]         press_d;
   logic [1:0][DW-1:0] dcnt_q;
   logic [1:0][DW-1:0] dcnt_d;

   state_t        state_q;
   state_t        state_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          slowclk_q;
   logic          slowclk_d;
   logic          tick_q;
   logic          tick_d;
   logic          running_q;
   logic          at_last;
   logic          pause_p;
   logic          step_p;

   assign btn_raw = {btn_step, btn_pause};
   assign pause_p = press_q[BP];
   assign step_p  = press_q[BS];
   assign at_last = (cnt_q == DIV_LAST);

   assign slowclk = slowclk_q;
   assign tick    = tick_q;
   assign running = running_q;

   // Debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
   always_comb begin
      deb_d   = deb_q;
      press_d = '0;
      dcnt_d  = dcnt_q;
      for (int i = 0; i < 2; i++) begin
         if (sync2_q[i] == deb_q[i]) begin
            dcnt_d[i] = '0;
         end else if (dcnt_q[i] == DEB_LAST) begin
            dcnt_d[i]  = '0;
            deb_d[i]   = ~deb_q[i];
            // only a rising debounced level is an event; releases are silent
            press_d[i] = ~deb_q[i];
         end else begin
            dcnt_d[i] = dcnt_q[i] + DW'(1);
         end
      end
   end

   // Button synchronisers, debounce state and registered press pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         deb_q   <= '0;
         press_q <= '0;
         dcnt_q  <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         deb_q   <= deb_d;
         press_q <= press_d;
         dcnt_q  <= dcnt_d;
      end
   end

   // Next-state logic: divider advance, slowclk toggling and run/pause/step sequencing.
   always_comb begin
      state_d   = state_q;
      cnt_d     = at_last ? '0 : cnt_q + CW'(1);
      slowclk_d = slowclk_q;
      tick_d    = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (pause_p && !slowclk_q) begin
               // low phase: stop right away, any pending rise is abandoned
               state_d = ST_PAUSED;
               cnt_d   = '0;
            end else begin
               if (at_last) begin
                  slowclk_d = ~slowclk_q;
                  tick_d    = ~slowclk_q;
               end
               if (pause_p) begin
                  // high phase: let it finish; if it ends on this very edge we are already low
                  state_d = at_last ? ST_PAUSED : ST_STOPPING;
               end
            end
         end
         ST_STOPPING: begin
            if (at_last) begin
               slowclk_d = ~slowclk_q;
               tick_d    = ~slowclk_q;
            end
            if (pause_p) begin
               state_d = ST_RUN;
            end else if (at_last) begin
               state_d = ST_PAUSED;
            end
         end
         ST_PAUSED: begin
            cnt_d     = '0;
            slowclk_d = 1'b0;
            if (pause_p) begin
               state_d = ST_RUN;
            end else if (step_p) begin
               state_d   = ST_STEP_HI;
               slowclk_d = 1'b1;
               tick_d    = 1'b1;
            end
         end
         ST_STEP_HI: begin
            if (at_last) begin
               slowclk_d = 1'b0;
               state_d   = ST_STEP_LO;
            end
         end
         ST_STEP_LO: begin
            if (at_last) begin
               state_d = ST_PAUSED;
            end
         end
         default: begin
            state_d   = ST_RUN;
            cnt_d     = '0;
            slowclk_d = 1'b0;
         end
      endcase
   end

   // State, divider and output registers; every output comes straight from a flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_RUN;
         cnt_q     <= '0;
         slowclk_q <= 1'b0;
         tick_q    <= 1'b0;
         running_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         slowclk_q <= slowclk_d;
         tick_q    <= tick_d;
         running_q <= (state_d == ST_RUN);
      end
   end

endmodule

// File: doc/slowclk_gen.md
Name: slowclk_gen

Overview:
Generates the free-running or single-stepped `slowclk` consumed by the state-counter stage, from the board system clock. Two raw push-buttons are synchronised and debounced. `btn_pause` toggles between free-run and paused. `btn_step` issues exactly one full `slowclk` period while paused. `slowclk` always comes straight from a flop, and its minimum high/low times are guaranteed.

Parameters:
HALF_PERIOD, 6000000, clk cycles per `slowclk` half-period (minimum 2; 1 Hz at 12 MHz).
DEBOUNCE_CYCLES, 120000, consecutive cycles a synchronised button level must differ from the debounced level before it is accepted (minimum 1).

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  asynchronous, active-high reset.
btn_pause  input  1  raw pause/run button, asynchronous, active-high.
btn_step  input  1  raw single-step button, asynchronous, active-high.
slowclk  output  1  registered divided clock to the downstream counter stage.
tick  output  1  one-clk-cycle pulse, high in the same cycle that `slowclk` first reads 1.
running  output  1  high in RUN state only.

Behaviour:
- Reset (async, any time): state=RUN, `slowclk`=0, `tick`=0, `running`=1. Divider counter, debounce counters, synchronisers, debounced levels and press pulses are all cleared.
- Input path, per button:
  - 2-flop synchroniser.
  - Debounce counter increments while the synchronised level differs from the debounced level, and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the level still differs, the debounced level toggles and the counter clears.
  - Press pulse = registered (debounced rise), high for 1 cycle. Releases produce no event.
  - Latency: button high before clk edge N gives a press pulse in cycle N+DEBOUNCE_CYCLES+2. The FSM acts at the next edge.
- Divider: counter width = clog2(HALF_PERIOD). It counts 0..HALF_PERIOD-1. At terminal count it wraps to 0 and a toggle event occurs: `slowclk`<=~`slowclk` and `tick`<=~`slowclk`. `tick` is otherwise 0.
- FSM states and transitions:
  - RUN: divider counts; toggles on every terminal count.
    - pause press: if `slowclk`=0, go to PAUSED immediately (counter cleared). If `slowclk`=1, go to STOPPING.
    - step press: ignored.
  - STOPPING: divider keeps counting. At the next toggle (`slowclk` falls), go to PAUSED with counter cleared.
    - pause press: returns to RUN with no disturbance to counter or `slowclk`.
    - step press: ignored.
  - PAUSED: `slowclk`=0, counter held at 0.
    - pause press: go to RUN; the first rise occurs HALF_PERIOD cycles later.
    - step press: go to STEP_HI; `slowclk`<=1 and `tick`<=1 on the same edge.
  - STEP_HI: counts HALF_PERIOD cycles of `slowclk`=1 (including the entry cycle), then `slowclk`<=0 and go to STEP_LO.
  - STEP_LO: counts HALF_PERIOD cycles of low time, then go to PAUSED.
  - STEP_HI/STEP_LO: all presses are dropped, with no queuing.
- Simultaneous pause and step press in the same cycle: pause wins; step is dropped.
- Invariant: every `slowclk` high and low phase lasts exactly HALF_PERIOD cycles, except PAUSED low, which is unbounded. No runt pulses are ever produced.
- `running` = (state==RUN), registered. It is 0 in STOPPING.

Test Plan:
(Use HALF_PERIOD=4 and DEBOUNCE_CYCLES=3 throughout.)
- Release reset, buttons low → `slowclk` rises at the 4th clk edge, period 8 cycles, 50% duty; `tick` is a 1-cycle pulse at each rise; `running`=1 throughout 200 cycles.
- Pause press landing while `slowclk`=1 → `running`=0 at once; `slowclk` falls at its scheduled edge, then stays 0; no `tick` for the next 100 cycles.
- In PAUSED, hold `btn_step` 10 cycles → `slowclk` rises exactly 5 (DEBOUNCE_CYCLES+2) cycles after the button is sampled high, with 1 `tick`; high 4 cycles, then low ≥4. A second step press arriving during STEP_HI gives no extra pulse.
- Toggle `btn_step` every 2 cycles for 20 cycles (bounce) → no press event and `slowclk` stays 0. Then hold high → exactly one step.
- Assert `rst` asynchronously mid-STEP_HI → `slowclk`, `tick`=0 and `running`=1 before the next clk edge; after release, free-run resumes as in scenario 1.
- Pause press, then a second pause press while in STOPPING → back to RUN; the `slowclk` period is unbroken at 8 cycles, with no missed or extra `tick`.
